// File: rtl/ecc_mont_mult_seq.sv
// Request sequencer in front of one Montgomery multiplier: range-checks operands,
// issues a single start pulse, waits for the product under a watchdog and returns it.
module ecc_mont_mult_seq #(
    parameter int REG_SIZE = 384,
    parameter int RADIX    = 32,
    parameter int TIMEOUT  = 127
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                zeroize,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [1:0]          req_op_i,
    input  logic [REG_SIZE-1:0] req_opa_i,
    input  logic [REG_SIZE-1:0] req_opb_i,
    input  logic [REG_SIZE-1:0] n_i,
    input  logic [RADIX-1:0]    n_prime_i,
    input  logic [REG_SIZE-1:0] r2_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [REG_SIZE-1:0] rsp_data_o,
    output logic                rsp_err_o,
    output logic                mm_start_o,
    output logic [REG_SIZE-1:0] mm_opa_o,
    output logic [REG_SIZE-1:0] mm_opb_o,
    output logic [REG_SIZE-1:0] mm_n_o,
    output logic [RADIX-1:0]    mm_n_prime_o,
    input  logic [REG_SIZE-1:0] mm_p_i,
    input  logic                mm_ready_i,
    output logic                busy_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [1:0] OP_MUL     = 2'd0;
    localparam logic [1:0] OP_TO_MONT = 2'd1;
    localparam logic [1:0] OP_FR_MONT = 2'd2;
    localparam logic [1:0] OP_ILLEGAL = 2'd3;
    localparam logic [CNT_W-1:0]    CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]    CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]    CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [REG_SIZE-1:0] WORD_ZERO = {REG_SIZE{1'b0}};
    localparam logic [REG_SIZE-1:0] WORD_ONE  = {{(REG_SIZE-1){1'b0}}, 1'b1};
    localparam logic [RADIX-1:0]    NP_ZERO   = {RADIX{1'b0}};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    state_t              state_r, state_s;
    logic [1:0]          op_r;
    logic [REG_SIZE-1:0] opa_r, opb_r, n_r, data_r, data_s, opb_eff_s;
    logic [RADIX-1:0]    n_prime_r;
    logic [CNT_W-1:0]    cnt_r, cnt_s;
    logic                err_r, err_s;
    logic                start_r, valid_r, busy_r;
    logic                accept_s, check_fail_s;

    // Operand B implied by the request type
    always_comb begin
        case (req_op_i)
            OP_MUL:     opb_eff_s = req_opb_i;
            OP_TO_MONT: opb_eff_s = r2_i;
            OP_FR_MONT: opb_eff_s = WORD_ONE;
            default:    opb_eff_s = WORD_ZERO;
        endcase
    end

    // Next-state, watchdog and response datapath
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        data_s       = data_r;
        err_s        = err_r;
        accept_s     = 1'b0;
        check_fail_s = (op_r == OP_ILLEGAL) || (opa_r >= n_r) || (opb_r >= n_r);
        case (state_r)
            ST_IDLE: begin
                if (req_valid_i) begin
                    accept_s = 1'b1;
                    state_s  = ST_CHECK;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (check_fail_s) begin
                    state_s = ST_RESP;
                    data_s  = WORD_ZERO;
                    err_s   = 1'b1;
                end else begin
                    state_s = ST_START;
                end
            end
            ST_START: begin
                cnt_s   = CNT_ZERO;
                state_s = ST_WAIT;
            end
            ST_WAIT: begin
                // A product arriving on the last watchdog cycle still wins
                if (mm_ready_i) begin
                    state_s = ST_RESP;
                    data_s  = mm_p_i;
                    err_s   = 1'b0;
                end else if (cnt_r == CNT_MAX) begin
                    state_s = ST_RESP;
                    data_s  = WORD_ZERO;
                    err_s   = 1'b1;
                end else begin
                    cnt_s   = cnt_r + CNT_ONE;
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_s = ST_IDLE;
                    data_s  = WORD_ZERO;
                    err_s   = 1'b0;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: begin
                state_s = ST_IDLE;
                data_s  = WORD_ZERO;
                err_s   = 1'b0;
            end
        endcase
    end

    // State, captured request and registered status outputs
    always_ff @(posedge clk) begin
        if (!reset_n || zeroize) begin
            state_r   <= ST_IDLE;
            op_r      <= OP_MUL;
            opa_r     <= WORD_ZERO;
            opb_r     <= WORD_ZERO;
            n_r       <= WORD_ZERO;
            n_prime_r <= NP_ZERO;
            data_r    <= WORD_ZERO;
            err_r     <= 1'b0;
            cnt_r     <= CNT_ZERO;
            start_r   <= 1'b0;
            valid_r   <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r <= state_s;
            data_r  <= data_s;
            err_r   <= err_s;
            cnt_r   <= cnt_s;
            start_r <= (state_s == ST_START);
            valid_r <= (state_s == ST_RESP);
            busy_r  <= (state_s != ST_IDLE);
            if (accept_s) begin
                op_r      <= req_op_i;
                opa_r     <= req_opa_i;
                opb_r     <= opb_eff_s;
                n_r       <= n_i;
                n_prime_r <= n_prime_i;
            end else begin
                op_r      <= op_r;
            end
        end
    end

    assign req_ready_o  = ~busy_r;
    assign busy_o       = busy_r;
    assign rsp_valid_o  = valid_r;
    assign rsp_data_o   = data_r;
    assign rsp_err_o    = err_r;
    assign mm_start_o   = start_r;
    assign mm_opa_o     = opa_r;
    assign mm_opb_o     = opb_r;
    assign mm_n_o       = n_r;
    assign mm_n_prime_o = n_prime_r;

endmodule

// File: tb/tb_ecc_mont_mult_seq.sv
// Bench for ecc_mont_mult_seq: behavioural multiplier stub, transaction-level
// model with a per-cycle compare, and directed timing/boundary checks.
module tb_ecc_mont_mult_seq;

    localparam int W   = 384;
    localparam int RX  = 32;
    localparam int TO  = 127;
    localparam int LAT = 41;
    localparam logic [W-1:0] P384 =
        384'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFFFF_00000000_00000000_FFFFFFFF;
    // 2^416 mod P-384, reduced by hand from 2^384 = 2^128 + 2^96 - 2^32 + 1
    localparam logic [W-1:0] R_MOD_P = 384'h1_00000000_FFFFFFFF_FFFFFFFF_00000001_00000000;
    localparam logic [W-1:0] ONE = 384'd1;

    logic          clk, reset_n, zeroize;
    logic          req_valid_i, req_ready_o, rsp_valid_o, rsp_ready_i, rsp_err_o;
    logic [1:0]    req_op_i;
    logic [W-1:0]  req_opa_i, req_opb_i, n_i, r2_i, rsp_data_o;
    logic [W-1:0]  mm_opa_o, mm_opb_o, mm_n_o, mm_p_i;
    logic [RX-1:0] n_prime_i, mm_n_prime_o;
    logic          mm_start_o, mm_ready_i, busy_o;

    ecc_mont_mult_seq #(.REG_SIZE(W), .RADIX(RX), .TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n), .zeroize(zeroize),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
        .req_opa_i(req_opa_i), .req_opb_i(req_opb_i), .n_i(n_i), .n_prime_i(n_prime_i),
        .r2_i(r2_i), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o), .mm_start_o(mm_start_o),
        .mm_opa_o(mm_opa_o), .mm_opb_o(mm_opb_o), .mm_n_o(mm_n_o),
        .mm_n_prime_o(mm_n_prime_o), .mm_p_i(mm_p_i), .mm_ready_i(mm_ready_i),
        .busy_o(busy_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    task automatic chk1(input string name, input logic got, input logic exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, got, exp);
        end
    endtask

    task automatic chki(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, got, exp);
        end
    endtask

    // a*b*2^-416 mod n by bit-serial halving
    function automatic logic [W-1:0] montmul(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [W-1:0] n);
        logic [800:0] t;
        t = 801'(a) * 801'(b);
        for (int i = 0; i < 416; i++) begin
            if (t[0]) t = t + 801'(n);
            t = t >> 1;
        end
        if (t >= 801'(n)) t = t - 801'(n);
        return t[W-1:0];
    endfunction

    function automatic logic [W-1:0] mulmod(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [W-1:0] n);
        logic [1199:0] x;
        x = (1200'(a) * 1200'(b)) % 1200'(n);
        return x[W-1:0];
    endfunction

    function automatic logic [W-1:0] eff_opb(input logic [1:0] op, input logic [W-1:0] b,
                                             input logic [W-1:0] r2);
        case (op)
            2'd0:    return b;
            2'd1:    return r2;
            2'd2:    return ONE;
            default: return 384'd0;
        endcase
    endfunction

    // ---------------- multiplier stub ----------------
    bit           stub_never = 1'b0;
    int           inject_req = 0;
    int           inject_done = 0;
    int           stub_cnt = 0;
    logic [W-1:0] s_a, s_b, s_n;

    initial begin
        mm_ready_i = 1'b0;
        mm_p_i     = 384'd0;
        forever begin
            @(posedge clk);
            #1;
            mm_ready_i = 1'b0;
            if (inject_req != inject_done) begin
                inject_done = inject_req;
                mm_p_i      = {W{1'b1}};
                mm_ready_i  = 1'b1;
            end else if (stub_cnt > 0) begin
                stub_cnt--;
                if (stub_cnt == 0) begin
                    mm_p_i     = montmul(s_a, s_b, s_n);
                    mm_ready_i = 1'b1;
                end
            end else if (mm_start_o && !stub_never) begin
                s_a = mm_opa_o; s_b = mm_opb_o; s_n = mm_n_o;
                stub_cnt = LAT;
            end
        end
    end

    // ---------------- transaction model ----------------
    logic          m_busy = 1'b0;
    logic          m_zero = 1'b1;
    logic          m_err = 1'b0;
    logic          m_chk_err = 1'b0;
    logic [W-1:0]  m_data, m_opa, m_opb;
    logic [RX-1:0] m_np;
    bit            armed = 1'b0;

    always @(posedge clk) begin
        if (!reset_n || zeroize) begin
            m_busy <= 1'b0;
            m_zero <= 1'b1;
        end else if (!m_busy) begin
            if (req_valid_i) begin
                m_busy    <= 1'b1;
                m_zero    <= 1'b0;
                m_opa     <= req_opa_i;
                m_opb     <= eff_opb(req_op_i, req_opb_i, r2_i);
                m_np      <= n_prime_i;
                m_chk_err <= (req_op_i == 2'd3) || (req_opa_i >= n_i) ||
                             (eff_opb(req_op_i, req_opb_i, r2_i) >= n_i);
                m_err     <= (req_op_i == 2'd3) || (req_opa_i >= n_i) ||
                             (eff_opb(req_op_i, req_opb_i, r2_i) >= n_i) || stub_never;
                m_data    <= ((req_op_i == 2'd3) || (req_opa_i >= n_i) ||
                              (eff_opb(req_op_i, req_opb_i, r2_i) >= n_i) || stub_never)
                             ? 384'd0 : montmul(req_opa_i, eff_opb(req_op_i, req_opb_i, r2_i), n_i);
            end
        end else if (rsp_valid_o && rsp_ready_i) begin
            m_busy <= 1'b0;
        end
    end

    // Per-cycle compare against the model
    int starts = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (armed) begin
                if (!m_busy) starts = 0;
                else if (mm_start_o) starts++;
                chk1("busy", busy_o, m_busy);
                chk1("req_ready", req_ready_o, !m_busy);
                if (!m_busy) begin
                    chk1("idle_rsp_valid", rsp_valid_o, 1'b0);
                    chk1("idle_mm_start", mm_start_o, 1'b0);
                end
                if (m_zero) begin
                    chk("clr_rsp_data", rsp_data_o, 384'd0);
                    chk1("clr_rsp_err", rsp_err_o, 1'b0);
                    chk("clr_mm_opa", mm_opa_o, 384'd0);
                    chk("clr_mm_opb", mm_opb_o, 384'd0);
                    chk("clr_mm_n", mm_n_o, 384'd0);
                    chk("clr_mm_np", {352'd0, mm_n_prime_o}, 384'd0);
                end
                if (mm_start_o) begin
                    chk("mm_opa", mm_opa_o, m_opa);
                    chk("mm_opb", mm_opb_o, m_opb);
                    chk("mm_n", mm_n_o, n_i);
                    chk("mm_np", {352'd0, mm_n_prime_o}, {352'd0, m_np});
                end
                if (rsp_valid_o) begin
                    chk("rsp_data", rsp_data_o, m_data);
                    chk1("rsp_err", rsp_err_o, m_err);
                    chki("start_count", starts, m_chk_err ? 0 : 1);
                end
            end
        end
    end

    // ---------------- directed sequence ----------------
    task automatic send(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int g;
        g = 0;
        req_op_i = op; req_opa_i = a; req_opb_i = b; req_valid_i = 1'b1;
        while (!req_ready_o && g < 300) begin
            @(negedge clk);
            g++;
        end
        chk1("accept", req_ready_o, 1'b1);
        @(negedge clk);
        req_valid_i = 1'b0;
    endtask

    // c counts cycles from accept (CHECK cycle is 1)
    task automatic wait_rsp(output int c, output int sc, output int rc);
        c = 1; sc = -1; rc = -1;
        while (!rsp_valid_o && c < 400) begin
            if (mm_start_o && sc < 0) sc = c;
            if (mm_ready_i && rc < 0) rc = c;
            @(negedge clk);
            c++;
        end
        chk1("rsp_arrives", rsp_valid_o, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench timeout");
    end

    logic [1199:0] wide;
    logic [W-1:0]  r_mod, a_v, b_v, a_m, b_m, ref_v;
    int            c, sc, rc;

    initial begin
        reset_n = 1'b0; zeroize = 1'b0; req_valid_i = 1'b0; req_op_i = 2'd0;
        req_opa_i = 384'd0; req_opb_i = 384'd0; rsp_ready_i = 1'b1;
        n_i = P384; n_prime_i = 32'd1;
        wide  = (1200'd1 << 416) % 1200'(P384);
        r_mod = wide[W-1:0];
        r2_i  = mulmod(r_mod, r_mod, P384);
        repeat (2) @(negedge clk);
        armed   = 1'b1;
        reset_n = 1'b1;

        chk("pin_r_mod", r_mod, R_MOD_P);
        chk("pin_montmul_one", montmul(R_MOD_P, ONE, P384), ONE);
        chk1("rst_req_ready", req_ready_o, 1'b1);
        chk1("rst_busy", busy_o, 1'b0);
        chk1("rst_rsp_valid", rsp_valid_o, 1'b0);
        chk1("rst_mm_start", mm_start_o, 1'b0);
        chk("rst_rsp_data", rsp_data_o, 384'd0);

        // FROM_MONT of R mod n gives 1
        send(2'd2, R_MOD_P, 384'h55);
        wait_rsp(c, sc, rc);
        chki("from_start_lat", sc, 2);
        chki("from_rsp_after_ready", c, rc + 1);
        chk("from_data", rsp_data_o, ONE);
        chk1("from_err", rsp_err_o, 1'b0);

        // TO_MONT of 1 gives R mod n
        send(2'd1, ONE, 384'd0);
        wait_rsp(c, sc, rc);
        chk("to_data", rsp_data_o, R_MOD_P);

        // MUL of Montgomery forms gives abR mod n
        a_v = 384'h0123456789ABCDEF_FEDCBA9876543210_0F1E2D3C4B5A6978;
        b_v = 384'hDEADBEEF_CAFEBABE_01234567_89ABCDEF_55AA55AA_12345678_9ABCDEF0_0FEDCBA9;
        a_m = mulmod(a_v, R_MOD_P, P384);
        b_m = mulmod(b_v, R_MOD_P, P384);
        ref_v = mulmod(mulmod(a_v, b_v, P384), R_MOD_P, P384);
        send(2'd0, a_m, b_m);
        wait_rsp(c, sc, rc);
        chk("mul_data", rsp_data_o, ref_v);

        // Largest legal operand
        send(2'd0, P384 - ONE, ONE);
        wait_rsp(c, sc, rc);
        chk1("max_opa_err", rsp_err_o, 1'b0);

        // Illegal op, opa == n, opb == n: error two cycles after accept
        send(2'd3, 384'd5, 384'd0);
        wait_rsp(c, sc, rc);
        chki("illegal_lat", c, 2);
        chk1("illegal_err", rsp_err_o, 1'b1);
        chk("illegal_data", rsp_data_o, 384'd0);
        chk1("illegal_no_start", sc < 0, 1'b1);
        send(2'd0, P384, ONE);
        wait_rsp(c, sc, rc);
        chki("opa_eq_n_lat", c, 2);
        chk1("opa_eq_n_err", rsp_err_o, 1'b1);
        chk1("opa_eq_n_no_start", sc < 0, 1'b1);
        send(2'd0, ONE, P384);
        wait_rsp(c, sc, rc);
        chk1("opb_eq_n_err", rsp_err_o, 1'b1);

        // Watchdog: TIMEOUT+1 WAIT cycles then error, stale ready ignored
        stub_never = 1'b1;
        send(2'd0, 384'd3, 384'd4);
        wait_rsp(c, sc, rc);
        chki("timeout_start", sc, 2);
        chki("timeout_lat", c, TO + 4);
        chk1("timeout_err", rsp_err_o, 1'b1);
        chk("timeout_data", rsp_data_o, 384'd0);
        stub_never = 1'b0;
        @(negedge clk);
        inject_req++;
        repeat (3) @(negedge clk);
        chk1("stale_busy", busy_o, 1'b0);
        chk1("stale_rsp_valid", rsp_valid_o, 1'b0);

        // Backpressure with a pending request, then back-to-back accept
        rsp_ready_i = 1'b0;
        send(2'd1, 384'd7, 384'd0);
        wait_rsp(c, sc, rc);
        req_op_i = 2'd0; req_opa_i = 384'd2; req_opb_i = 384'd3; req_valid_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk1("hold_valid", rsp_valid_o, 1'b1);
            chk1("hold_req_ready", req_ready_o, 1'b0);
            chk("hold_data", rsp_data_o, mulmod(384'd7, R_MOD_P, P384));
        end
        rsp_ready_i = 1'b1;
        @(negedge clk);
        chk1("b2b_idle_ready", req_ready_o, 1'b1);
        @(negedge clk);
        chk1("b2b_accepted", busy_o, 1'b1);
        req_valid_i = 1'b0;
        wait_rsp(c, sc, rc);
        chk("b2b_data", rsp_data_o, montmul(384'd2, 384'd3, P384));

        // Zeroize in WAIT; the late product pulse lands in IDLE
        send(2'd0, 384'd9, 384'd10);
        repeat (10) @(negedge clk);
        zeroize = 1'b1;
        @(negedge clk);
        zeroize = 1'b0;
        chk1("zero_busy", busy_o, 1'b0);
        chk1("zero_req_ready", req_ready_o, 1'b1);
        chk("zero_mm_opa", mm_opa_o, 384'd0);
        chk("zero_mm_n", mm_n_o, 384'd0);
        repeat (60) @(negedge clk);
        chk1("zero_stale_valid", rsp_valid_o, 1'b0);

        // reset_n pulse in RESP
        rsp_ready_i = 1'b0;
        send(2'd3, 384'd0, 384'd0);
        wait_rsp(c, sc, rc);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk1("rst_resp_valid", rsp_valid_o, 1'b0);
        chk1("rst_resp_busy", busy_o, 1'b0);
        chk1("rst_resp_err", rsp_err_o, 1'b0);
        rsp_ready_i = 1'b1;

        send(2'd2, R_MOD_P, 384'd0);
        wait_rsp(c, sc, rc);
        chk("recover_data", rsp_data_o, ONE);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
